inst_trace_buffer: RTL and testbench

Parametrised instruction trace capture block for GP-GPU debug. It taps one pipeline stage (valid, one-hot warp ID, PC, instruction) and decodes each instruction into an opcode class with zero latency. Selected records are stored in a circular buffer with trigger, wrap/stop modes, per-warp instruction counters and drop accounting. A ready/valid port drains the buffer to a testbench or a debug bus.

---
 rtl/inst_trace_buffer.sv | 179 +++++++++++++++++
 tb/tb_inst_trace_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_trace_buffer.sv
// Instruction trace capture for GP-GPU debug: zero-latency opcode decode, triggered
// circular trace buffer with wrap/freeze modes, per-warp and drop accounting.
module inst_trace_buffer #(
  parameter int NUM_WARPS = 8,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 16,
  localparam int WID_W    = $clog2(NUM_WARPS),
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int COUNT_W  = PTR_W + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [NUM_WARPS-1:0]       one_hot_warp_ID,
  input  logic [31:0]                PC,
  input  logic [31:0]                instruction_in,
  input  logic                       mode_wrap,
  input  logic                       trig_en,
  input  logic [31:0]                trig_PC,
  input  logic                       clear,
  output logic [3:0]                 dec_class,
  output logic                       dec_dot_S,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [WID_W-1:0]           rd_warp_ID,
  output logic [31:0]                rd_PC,
  output logic [31:0]                rd_instruction,
  output logic [3:0]                 rd_class,
  output logic [COUNT_W-1:0]         count,
  output logic [1:0]                 state,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [NUM_WARPS*CNT_W-1:0] warp_inst_cnt,
  output logic                       onehot_err
);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);
  localparam int REC_W = WID_W + 32 + 32 + 4;

  state_t               state_q;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [COUNT_W-1:0]   count_q;
  logic [CNT_W-1:0]     drop_q;
  logic [CNT_W-1:0]     wcnt [NUM_WARPS];
  logic                 err_q;
  logic [REC_W-1:0]     mem [DEPTH];

  logic [5:0]           opc;
  logic [5:0]           funct;
  logic [WID_W-1:0]     warp_bin;
  logic                 tap_legal;
  logic                 tap_illegal;
  logic                 pop;
  logic                 full;
  logic                 want_write;
  logic                 do_write;
  logic                 overwrite;
  logic                 freeze_drop;
  logic                 drop_evt;

  assign opc       = instruction_in[31:26];
  assign funct     = instruction_in[5:0];
  assign dec_dot_S = instruction_in[30];

  // Opcode bit 4 (instruction bit 30) is the .S flag and is a don't-care for most classes
  always_comb begin
    dec_class = 4'd15;
    casez (opc)
      6'b0?0000: begin
        case (funct)
          6'b100000, 6'b100010, 6'b011000, 6'b100100,
          6'b100101, 6'b100110, 6'b000010, 6'b000000: dec_class = 4'd0;
          default:                                    dec_class = 4'd15;
        endcase
      end
      6'b0?1000, 6'b0?1100, 6'b0?1101, 6'b0?1110: dec_class = 4'd1;
      6'b1?0011: dec_class = 4'd2;
      6'b1?0111: dec_class = 4'd3;
      6'b1?1011: dec_class = 4'd4;
      6'b1?1111: dec_class = 4'd5;
      6'b0?0100: dec_class = 4'd6;
      6'b0?0111: dec_class = 4'd7;
      6'b0?0010: dec_class = 4'd8;
      6'b000011: dec_class = 4'd9;
      6'b000110: dec_class = 4'd10;
      6'b100001: dec_class = 4'd11;
      6'b0?0001: dec_class = 4'd12;
      default:   dec_class = 4'd15;
    endcase
  end

  always_comb begin
    warp_bin = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (one_hot_warp_ID[i]) warp_bin = warp_bin | WID_W'(i);
    end
  end

  assign tap_legal   = in_valid && $onehot(one_hot_warp_ID);
  assign tap_illegal = in_valid && !$onehot(one_hot_warp_ID);
  assign rd_valid    = (count_q != '0);
  assign pop         = rd_valid && rd_ready;
  assign full        = (count_q == FULL_COUNT);

  always_comb begin
    want_write = 1'b0;
    case (state_q)
      ARMED:   want_write = tap_legal && (!trig_en || (PC == trig_PC));
      CAPTURE: want_write = tap_legal;
      default: want_write = 1'b0;
    endcase
  end

  // A full buffer still accepts a write when the head is popped in the same cycle
  assign do_write    = want_write && (!full || pop || mode_wrap);
  assign overwrite   = want_write && full && !pop && mode_wrap;
  assign freeze_drop = want_write && full && !pop && !mode_wrap;
  assign drop_evt    = tap_illegal || overwrite || freeze_drop ||
                       ((state_q == FROZEN) && tap_legal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARMED;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) wcnt[w] <= '0;
    end else if (clear) begin
      state_q <= ARMED;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) wcnt[w] <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop || overwrite) rd_ptr <= rd_ptr + 1'b1;

      if (do_write && !pop && !full) count_q <= count_q + 1'b1;
      else if (pop && !do_write)     count_q <= count_q - 1'b1;

      if (do_write && (state_q == ARMED)) state_q <= CAPTURE;
      else if (freeze_drop)               state_q <= FROZEN;

      if (drop_evt && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      if (tap_illegal) err_q <= 1'b1;

      for (int w = 0; w < NUM_WARPS; w++) begin
        if (tap_legal && one_hot_warp_ID[w] && (wcnt[w] != '1)) wcnt[w] <= wcnt[w] + 1'b1;
      end
    end
  end

  // Record storage carries no reset; contents are only meaningful while count is nonzero
  always_ff @(posedge clk) begin
    if (do_write && !clear) mem[wr_ptr] <= {warp_bin, PC, instruction_in, dec_class};
  end

  assign {rd_warp_ID, rd_PC, rd_instruction, rd_class} = mem[rd_ptr];

  assign count      = count_q;
  assign state      = state_q;
  assign drop_cnt   = drop_q;
  assign onehot_err = err_q;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_wcnt
    assign warp_inst_cnt[g*CNT_W +: CNT_W] = wcnt[g];
  end

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Directed self-checking bench for inst_trace_buffer; small CNT_W exposes saturation.
module tb_inst_trace_buffer;

  localparam int NW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [NW-1:0] one_hot_warp_ID = 8'b1;
  logic [31:0]   PC = '0;
  logic [31:0]   instruction_in = 32'h0022_1820;
  logic          mode_wrap = 1'b0;
  logic          trig_en = 1'b0;
  logic [31:0]   trig_PC = '0;
  logic          clear = 1'b0;
  logic [3:0]    dec_class;
  logic          dec_dot_S;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [2:0]    rd_warp_ID;
  logic [31:0]   rd_PC;
  logic [31:0]   rd_instruction;
  logic [3:0]    rd_class;
  logic [4:0]    count;
  logic [1:0]    state;
  logic [CW-1:0] drop_cnt;
  logic [NW*CW-1:0] warp_inst_cnt;
  logic          onehot_err;

  int total = 0;
  int bad = 0;

  inst_trace_buffer #(.NUM_WARPS(NW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .one_hot_warp_ID(one_hot_warp_ID),
    .PC(PC), .instruction_in(instruction_in), .mode_wrap(mode_wrap), .trig_en(trig_en),
    .trig_PC(trig_PC), .clear(clear), .dec_class(dec_class), .dec_dot_S(dec_dot_S),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_warp_ID(rd_warp_ID), .rd_PC(rd_PC),
    .rd_instruction(rd_instruction), .rd_class(rd_class), .count(count), .state(state),
    .drop_cnt(drop_cnt), .warp_inst_cnt(warp_inst_cnt), .onehot_err(onehot_err)
  );

  always #5 clk = ~clk;

  task automatic tap(input logic [NW-1:0] oh, input logic [31:0] pc);
    in_valid = 1'b1;
    one_hot_warp_ID = oh;
    PC = pc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
    total++; if (count !== 5'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (drop_cnt !== '0) begin bad++; $display("[TB] FAIL reset_drop got=%0d exp=0", drop_cnt); end
    total++; if (warp_inst_cnt !== '0) begin bad++; $display("[TB] FAIL reset_warpcnt got=%h exp=0", warp_inst_cnt); end
    total++; if (onehot_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_onehot_err got=%b exp=0", onehot_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] vec [5];
    logic [3:0]  exp_cls [5];
    logic        exp_s [5];
    vec[0] = 32'h0022_1820; exp_cls[0] = 4'd0;  exp_s[0] = 1'b0;
    vec[1] = 32'h4022_1820; exp_cls[1] = 4'd0;  exp_s[1] = 1'b1;
    vec[2] = 32'h0C00_0005; exp_cls[2] = 4'd9;  exp_s[2] = 1'b0;
    vec[3] = 32'h8400_0000; exp_cls[3] = 4'd11; exp_s[3] = 1'b0;
    vec[4] = 32'h0000_0001; exp_cls[4] = 4'd15; exp_s[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      instruction_in = vec[i];
      #1;
      total++;
      if (dec_class !== exp_cls[i]) begin
        bad++; $display("[TB] FAIL decode_class[%0d] instr=%h got=%0d exp=%0d", i, vec[i], dec_class, exp_cls[i]);
      end
      total++;
      if (dec_dot_S !== exp_s[i]) begin
        bad++; $display("[TB] FAIL decode_dotS[%0d] got=%b exp=%b", i, dec_dot_S, exp_s[i]);
      end
    end
    instruction_in = 32'h0022_1820;
  endtask

  task automatic test_trigger();
    trig_en = 1'b1;
    trig_PC = 32'h10;
    tap(8'b0000_0100, 32'h0);
    tap(8'b0000_0100, 32'h4);
    total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL trig_armed got=%0d exp=0", state); end
    tap(8'b0000_0100, 32'h10);
    tap(8'b0000_0100, 32'h14);
    total++; if (count !== 5'd2) begin bad++; $display("[TB] FAIL trig_count got=%0d exp=2", count); end
    total++; if (rd_PC !== 32'h10) begin bad++; $display("[TB] FAIL trig_head_pc got=%h exp=10", rd_PC); end
    total++; if (rd_warp_ID !== 3'd2) begin bad++; $display("[TB] FAIL trig_head_warp got=%0d exp=2", rd_warp_ID); end
    total++; if (rd_class !== 4'd0) begin bad++; $display("[TB] FAIL trig_head_class got=%0d exp=0", rd_class); end
    total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL trig_state got=%0d exp=1", state); end
    total++; if (warp_inst_cnt[2*CW +: CW] !== 4'd4) begin bad++; $display("[TB] FAIL trig_warpcnt got=%0d exp=4", warp_inst_cnt[2*CW +: CW]); end
    total++; if (drop_cnt !== '0) begin bad++; $display("[TB] FAIL trig_drop got=%0d exp=0", drop_cnt); end
    trig_en = 1'b0;
  endtask

  task automatic test_clear();
    clear = 1'b1;
    in_valid = 1'b1;
    one_hot_warp_ID = 8'b0000_0100;
    PC = 32'h20;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("[TB] FAIL clear_count got=%0d exp=0", count); end
    total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL clear_state got=%0d exp=0", state); end
    total++; if (warp_inst_cnt !== '0) begin bad++; $display("[TB] FAIL clear_warpcnt got=%h exp=0", warp_inst_cnt); end
  endtask

  task automatic test_freeze();
    mode_wrap = 1'b0;
    rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) tap(8'b0000_0001, 32'(i * 4));
    total++; if (count !== 5'd16) begin bad++; $display("[TB] FAIL freeze_count got=%0d exp=16", count); end
    total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL freeze_state got=%0d exp=2", state); end
    total++; if (drop_cnt !== 4'd4) begin bad++; $display("[TB] FAIL freeze_drop got=%0d exp=4", drop_cnt); end
    total++; if (rd_PC !== 32'h0) begin bad++; $display("[TB] FAIL freeze_head_pc got=%h exp=0", rd_PC); end
    total++; if (warp_inst_cnt[0 +: CW] !== 4'd15) begin bad++; $display("[TB] FAIL freeze_warpcnt_sat got=%0d exp=15", warp_inst_cnt[0 +: CW]); end
    do_clear();
  endtask

  task automatic test_wrap();
    mode_wrap = 1'b1;
    for (int i = 0; i < 20; i++) tap(8'b0000_0010, 32'(i * 4));
    total++; if (count !== 5'd16) begin bad++; $display("[TB] FAIL wrap_count got=%0d exp=16", count); end
    total++; if (rd_PC !== 32'h10) begin bad++; $display("[TB] FAIL wrap_head_pc got=%h exp=10", rd_PC); end
    total++; if (drop_cnt !== 4'd4) begin bad++; $display("[TB] FAIL wrap_drop got=%0d exp=4", drop_cnt); end
    total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL wrap_state got=%0d exp=1", state); end
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (!rd_valid || rd_PC !== 32'(32'h10 + k * 4)) begin
        bad++; $display("[TB] FAIL wrap_drain[%0d] valid=%b got=%h exp=%h", k, rd_valid, rd_PC, 32'(32'h10 + k * 4));
      end
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0 || count !== 5'd0) begin bad++; $display("[TB] FAIL wrap_empty valid=%b count=%0d exp 0/0", rd_valid, count); end
    mode_wrap = 1'b0;
    do_clear();
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 16; i++) tap(8'b0000_1000, 32'(32'h100 + i * 4));
    total++; if (count !== 5'd16) begin bad++; $display("[TB] FAIL fullpop_fill got=%0d exp=16", count); end
    rd_ready = 1'b1;
    tap(8'b0000_1000, 32'h140);
    rd_ready = 1'b0;
    total++; if (count !== 5'd16) begin bad++; $display("[TB] FAIL fullpop_count got=%0d exp=16", count); end
    total++; if (drop_cnt !== 4'd0) begin bad++; $display("[TB] FAIL fullpop_drop got=%0d exp=0", drop_cnt); end
    total++; if (rd_PC !== 32'h104) begin bad++; $display("[TB] FAIL fullpop_head got=%h exp=104", rd_PC); end
    total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL fullpop_state got=%0d exp=1", state); end
  endtask

  task automatic test_error_reset();
    tap(8'b0000_0110, 32'h200);
    total++; if (onehot_err !== 1'b1) begin bad++; $display("[TB] FAIL err_flag got=%b exp=1", onehot_err); end
    total++; if (drop_cnt !== 4'd1) begin bad++; $display("[TB] FAIL err_drop got=%0d exp=1", drop_cnt); end
    total++; if (count !== 5'd16) begin bad++; $display("[TB] FAIL err_count got=%0d exp=16", count); end
    do_clear();
    total++; if (drop_cnt !== 4'd0 || onehot_err !== 1'b0) begin bad++; $display("[TB] FAIL err_clear drop=%0d err=%b exp 0/0", drop_cnt, onehot_err); end
    total++; if (state !== 2'd0 || warp_inst_cnt !== '0) begin bad++; $display("[TB] FAIL err_clear_state state=%0d wcnt=%h exp 0/0", state, warp_inst_cnt); end
    tap(8'b1000_0000, 32'h300);
    tap(8'b1000_0000, 32'h304);
    total++; if (count !== 5'd2 || rd_warp_ID !== 3'd7) begin bad++; $display("[TB] FAIL pre_reset count=%0d warp=%0d exp 2/7", count, rd_warp_ID); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (count !== 5'd0 || state !== 2'd0) begin bad++; $display("[TB] FAIL midreset count=%0d state=%0d exp 0/0", count, state); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_trigger();
    test_clear();
    test_freeze();
    test_wrap();
    test_full_pop();
    test_error_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
